// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction-fetch port, data port and shared memory port.
// The arbiter uses the slave view; the environment drives through the master view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_gnt;
  logic        i_valid;
  logic        i_err;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_valid;
  logic        d_err;
  logic [63:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output i_gnt, i_valid, i_err, i_rdata,
    output d_gnt, d_valid, d_err, d_rdata,
    output m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  i_gnt, i_valid, i_err, i_rdata,
    input  d_gnt, d_valid, d_err, d_rdata,
    input  m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// data accesses; one outstanding access, 16-cycle timeout abort.
module mem_port_arbiter (
  input logic           clk,
  input logic           reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        last_d, last_d_n;
  logic        i_gnt, i_gnt_n, i_valid, i_valid_n, i_err, i_err_n;
  logic [31:0] i_rdata, i_rdata_n;
  logic        d_gnt, d_gnt_n, d_valid, d_valid_n, d_err, d_err_n;
  logic [63:0] d_rdata, d_rdata_n;
  logic        m_req, m_req_n, m_we, m_we_n;
  logic [63:0] m_addr, m_addr_n, m_wdata, m_wdata_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last_d  <= 1'b0;
      i_gnt   <= 1'b0;
      i_valid <= 1'b0;
      i_err   <= 1'b0;
      i_rdata <= '0;
      d_gnt   <= 1'b0;
      d_valid <= 1'b0;
      d_err   <= 1'b0;
      d_rdata <= '0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      last_d  <= last_d_n;
      i_gnt   <= i_gnt_n;
      i_valid <= i_valid_n;
      i_err   <= i_err_n;
      i_rdata <= i_rdata_n;
      d_gnt   <= d_gnt_n;
      d_valid <= d_valid_n;
      d_err   <= d_err_n;
      d_rdata <= d_rdata_n;
      m_req   <= m_req_n;
      m_we    <= m_we_n;
      m_addr  <= m_addr_n;
      m_wdata <= m_wdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    last_d_n  = last_d;
    i_gnt_n   = 1'b0;
    i_valid_n = 1'b0;
    i_err_n   = 1'b0;
    i_rdata_n = i_rdata;
    d_gnt_n   = 1'b0;
    d_valid_n = 1'b0;
    d_err_n   = 1'b0;
    d_rdata_n = d_rdata;
    m_req_n   = m_req;
    m_we_n    = m_we;
    m_addr_n  = m_addr;
    m_wdata_n = m_wdata;

    case (state)
      IDLE: begin
        // On a tie the port that did not own the previous access wins.
        if (bus.d_req && (!bus.i_req || !last_d)) begin
          state_n   = BUSY_D;
          d_gnt_n   = 1'b1;
          m_req_n   = 1'b1;
          m_we_n    = bus.d_we;
          m_addr_n  = bus.d_addr;
          m_wdata_n = bus.d_wdata;
          cnt_n     = '0;
          last_d_n  = 1'b1;
        end else if (bus.i_req) begin
          state_n   = BUSY_I;
          i_gnt_n   = 1'b1;
          m_req_n   = 1'b1;
          m_we_n    = 1'b0;
          m_addr_n  = bus.i_addr;
          m_wdata_n = '0;
          cnt_n     = '0;
          last_d_n  = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.m_ready) begin
          m_req_n = 1'b0;
          state_n = IDLE;
          if (state == BUSY_I) begin
            i_valid_n = 1'b1;
            i_rdata_n = bus.m_rdata[31:0];
          end else begin
            d_valid_n = 1'b1;
            d_rdata_n = m_we ? '0 : bus.m_rdata;
          end
        end else if (cnt == 4'd15) begin
          m_req_n = 1'b0;
          state_n = IDLE;
          if (state == BUSY_I) i_err_n = 1'b1;
          else                 d_err_n = 1'b1;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.i_gnt   = i_gnt;
  assign bus.i_valid = i_valid;
  assign bus.i_err   = i_err;
  assign bus.i_rdata = i_rdata;
  assign bus.d_gnt   = d_gnt;
  assign bus.d_valid = d_valid;
  assign bus.d_err   = d_err;
  assign bus.d_rdata = d_rdata;
  assign bus.m_req   = m_req;
  assign bus.m_we    = m_we;
  assign bus.m_addr  = m_addr;
  assign bus.m_wdata = m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: arbitration vector table, directed
// corner sequences, and randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       i_req;
    logic       d_req;
    logic       m_ready;
    logic [4:0] exp;  // {i_gnt, d_gnt, i_valid, d_valid, m_req} after the edge
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    check("reset_ctl", {bus.i_gnt, bus.i_valid, bus.i_err, bus.d_gnt, bus.d_valid,
                        bus.d_err, bus.m_req, bus.m_we}, 0);
    check("reset_data", bus.m_addr | bus.m_wdata | bus.d_rdata | {32'b0, bus.i_rdata}, 0);
    step();
    reset = 1'b0;
  endtask

  task automatic grant_d(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.m_ready = 1'b0;
    step();
    check("d_grant", {bus.d_gnt, bus.i_gnt, bus.m_req, bus.m_we}, {1'b1, 1'b0, 1'b1, we});
    check("d_grant_addr", bus.m_addr, addr);
    bus.d_req = 1'b0;
  endtask

  // Reference model state: owner -1 = memory free, 0 = fetch, 1 = data.
  int          owner;
  int          last;
  int          waited;
  logic [1:0]  rq;
  logic [1:0]  eg, ev, ee;
  logic [31:0] er_i;
  logic [63:0] er_d;
  logic        em_we;
  logic [63:0] em_addr, em_wdata;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 5'b01001};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 5'b00010};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 5'b10001};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 5'b00100};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 5'b01001};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 5'b00010};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 5'b10001};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 5'b00100};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 5'b00000};

    // Tie-breaking and alternation straight out of reset.
    do_reset();
    bus.i_addr = 64'h1000;
    bus.d_addr = 64'h2000;
    for (int unsigned i = 0; i < 9; i++) begin
      bus.i_req   = tbl[i].i_req;
      bus.d_req   = tbl[i].d_req;
      bus.m_ready = tbl[i].m_ready;
      step();
      check($sformatf("vec%0d", i),
            {bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.m_req}, tbl[i].exp);
    end

    // Simple fetch with minimum latency.
    do_reset();
    bus.i_req  = 1'b1;
    bus.i_addr = 64'h10;
    step();
    check("fetch_gnt", {bus.i_gnt, bus.d_gnt, bus.m_req, bus.m_we}, 4'b1010);
    check("fetch_addr", bus.m_addr, 64'h10);
    check("fetch_wdata", bus.m_wdata, 0);
    bus.i_req   = 1'b0;
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'hA5A5A5A5_00500093;
    step();
    check("fetch_valid", {bus.i_valid, bus.i_err, bus.i_gnt, bus.m_req}, 4'b1000);
    check("fetch_rdata", bus.i_rdata, 32'h00500093);
    bus.m_ready = 1'b0;
    bus.m_rdata = 64'h0;
    step();
    check("fetch_pulse", bus.i_valid, 1'b0);
    check("fetch_hold", bus.i_rdata, 32'h00500093);
    check("fetch_attr_hold", bus.m_addr, 64'h10);

    // Load, then a store that must clear d_rdata.
    grant_d(1'b0, 64'h200, 64'h0);
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'h11223344_55667788;
    step();
    check("load_valid", {bus.d_valid, bus.d_err}, 2'b10);
    check("load_rdata", bus.d_rdata, 64'h11223344_55667788);
    bus.m_ready = 1'b0;
    grant_d(1'b1, 64'h100, 64'hDEADBEEF);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      check("store_stable", {bus.m_req, bus.m_we, bus.m_wdata, bus.m_addr},
            {1'b1, 1'b1, 64'hDEADBEEF, 64'h100});
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check("store_valid", {bus.d_valid, bus.d_err, bus.m_req}, 3'b100);
    check("store_rdata", bus.d_rdata, 0);
    bus.m_ready = 1'b0;

    // Timeout abort after 16 busy cycles, then completion on the 16th.
    grant_d(1'b0, 64'h300, 64'h0);
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'h0000CAFE_0000CAFE;
    step();
    check("preload_rdata", bus.d_rdata, 64'h0000CAFE_0000CAFE);
    bus.m_ready = 1'b0;
    grant_d(1'b0, 64'h308, 64'h0);
    for (int unsigned i = 0; i < 15; i++) begin
      step();
      check($sformatf("tmo_wait%0d", i), {bus.d_err, bus.d_valid, bus.m_req}, 3'b001);
    end
    step();
    check("tmo_err", {bus.d_err, bus.d_valid, bus.m_req}, 3'b100);
    check("tmo_rdata", bus.d_rdata, 64'h0000CAFE_0000CAFE);
    step();
    check("tmo_pulse", bus.d_err, 1'b0);
    grant_d(1'b0, 64'h310, 64'h0);
    for (int unsigned i = 0; i < 15; i++) step();
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'h0BADF00D;
    step();
    check("late_ready", {bus.d_err, bus.d_valid, bus.m_req}, 3'b010);
    check("late_rdata", bus.d_rdata, 64'h0BADF00D);
    bus.m_ready = 1'b0;

    // Reset in the middle of a fetch, with a data request waiting.
    bus.i_req  = 1'b1;
    bus.i_addr = 64'h40;
    step();
    check("mid_gnt", {bus.i_gnt, bus.m_req}, 2'b11);
    bus.i_req  = 1'b0;
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 64'h80;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_mreq", bus.m_req, 1'b0);
    bus.m_ready = 1'b1;
    step();
    check("mid_rst_quiet", {bus.i_valid, bus.i_err, bus.d_gnt, bus.m_req}, 4'b0000);
    bus.m_ready = 1'b0;
    reset = 1'b0;
    step();
    check("post_rst_gnt", {bus.d_gnt, bus.i_gnt, bus.m_req}, 3'b101);
    check("post_rst_addr", bus.m_addr, 64'h80);
    bus.d_req   = 1'b0;
    bus.m_ready = 1'b1;
    bus.m_rdata = 64'h77;
    step();
    check("post_rst_valid", {bus.d_valid, bus.i_valid, bus.i_err}, 3'b100);
    bus.m_ready = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    owner = -1; last = 0; waited = 0; rq = 2'b00;
    er_i = '0; er_d = '0; em_we = 1'b0; em_addr = '0; em_wdata = '0;
    for (int unsigned cyc = 0; cyc < 800; cyc++) begin
      if (!rq[0] && $urandom_range(0, 2) == 0) begin
        rq[0] = 1'b1;
        bus.i_addr = {$urandom, $urandom};
      end
      if (!rq[1] && $urandom_range(0, 2) == 0) begin
        rq[1] = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = {$urandom, $urandom};
        bus.d_wdata = {$urandom, $urandom};
      end
      bus.i_req   = rq[0];
      bus.d_req   = rq[1];
      bus.m_ready = ($urandom_range(0, 6) == 0);
      bus.m_rdata = {$urandom, $urandom};

      eg = '0; ev = '0; ee = '0;
      if (owner < 0) begin
        if (rq != 2'b00) begin
          owner  = (rq == 2'b11) ? 1 - last : (rq[1] ? 1 : 0);
          last   = owner;
          waited = 0;
          eg[owner] = 1'b1;
          em_we    = (owner == 1) ? bus.d_we : 1'b0;
          em_addr  = (owner == 1) ? bus.d_addr : bus.i_addr;
          em_wdata = (owner == 1) ? bus.d_wdata : 64'h0;
        end
      end else if (bus.m_ready) begin
        ev[owner] = 1'b1;
        if (owner == 0) er_i = bus.m_rdata[31:0];
        else            er_d = em_we ? 64'h0 : bus.m_rdata;
        owner = -1;
      end else begin
        waited++;
        if (waited == 16) begin
          ee[owner] = 1'b1;
          owner = -1;
        end
      end

      step();
      check("rnd_ctl", {bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.i_err,
                        bus.d_err, bus.m_req, bus.m_we},
            {eg[0], eg[1], ev[0], ev[1], ee[0], ee[1], owner >= 0, em_we});
      check("rnd_i_rdata", bus.i_rdata, er_i);
      check("rnd_d_rdata", bus.d_rdata, er_d);
      check("rnd_m_addr", bus.m_addr, em_addr);
      check("rnd_m_wdata", bus.m_wdata, em_wdata);
      rq = rq & ~eg;
      bus.i_req = rq[0];
      bus.d_req = rq[1];
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 i_req  input  1  instruction-fetch request; held by requester until i_gnt.
REQ-004 i_addr  input  64  fetch byte address.
REQ-005 i_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-006 i_valid  output  1  one-cycle pulse: fetch completed, i_rdata valid.
REQ-007 i_err  output  1  one-cycle pulse: fetch aborted by timeout.
REQ-008 i_rdata  output  32  fetched instruction, held until next fetch completion.
REQ-009 d_req  input  1  data request (ld/sd); held until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  64  data byte address.
REQ-012 d_wdata  input  64  store data.
REQ-013 d_gnt / d_valid / d_err  output  1 each  same meaning as i_gnt / i_valid / i_err, for the data port.
REQ-014 d_rdata  output  64  load data; loaded with 0 on store completion; held otherwise.
REQ-015 m_req  output  1  memory access in progress.
REQ-016 m_we / m_addr / m_wdata  output  1/64/64  latched access attributes, stable while m_req=1.
REQ-017 m_rdata  input  64  memory read data, sampled when m_ready=1.
REQ-018 m_ready  input  1  memory completion strobe; ignored when m_req=0.

Function
REQ-019 FSM states: IDLE, BUSY_I, BUSY_D; one outstanding memory access at most.
REQ-020 IDLE, rising edge with only i_req=1 -> BUSY_I; only d_req=1 -> BUSY_D; neither -> stay IDLE.
REQ-021 IDLE, both requests -> grant the port not equal to last_owner (round-robin); last_owner updated on every grant.
REQ-022 On grant edge: matching gnt <= 1 for exactly one cycle, m_req <= 1, m_addr/m_we/m_wdata latched (fetch: m_we=0, m_wdata=0), timeout counter <= 0.
REQ-023 Grant latency: request sampled in IDLE at edge k -> gnt and m_req high during cycle k..k+1.
REQ-024 BUSY state, edge with m_ready=1: m_req <= 0, owner valid <= 1 for one cycle, owner rdata <= m_rdata (fetch: m_rdata[31:0]; store: d_rdata <= 0), state <= IDLE.
REQ-025 Earliest completion: m_ready=1 in first BUSY cycle; valid asserted the following cycle; next grant no earlier than the edge ending that IDLE cycle.
REQ-026 Requests asserted while in BUSY states are not accepted; they are evaluated on return to IDLE.
REQ-027 Timeout counter 4 bits: BUSY edge with m_ready=0 and counter<15 -> counter+1; counter==15 -> abort: m_req <= 0, owner err <= 1 for one cycle, rdata unchanged, state <= IDLE.
REQ-028 m_ready=1 on the edge where counter==15 -> normal completion; no err.
REQ-029 gnt, valid, err never asserted for both ports in the same cycle; valid and err never both for one port.
REQ-030 m_addr/m_we/m_wdata hold last latched values when m_req=0.

Reset
REQ-031 reset=1 -> immediately: state IDLE, all outputs 0 (gnt, valid, err, rdata, m_req, m_we, m_addr, m_wdata), counter 0, last_owner = instruction port (data wins first tie).
REQ-032 Reset mid-access drops m_req at once; no valid or err pulse for the aborted access.

Verification
REQ-033 Reset release, i_req=1 addr 0x10, m_ready=1 next cycle with m_rdata=0x00500093 -> i_gnt pulse, m_addr=0x10, m_we=0, then i_valid pulse, i_rdata=0x00500093.
REQ-034 Both req on first cycle after reset -> d_gnt first, i_gnt after d completion; repeat both -> order alternates I, D, I.
REQ-035 Store d_we=1 addr 0x100 wdata 0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF stable until m_ready; d_valid pulse, d_rdata=0.
REQ-036 Load with m_ready held low 16 busy cycles -> m_req drops, d_err one-cycle pulse, d_rdata unchanged; ready on 16th cycle -> d_valid, no d_err.
REQ-037 Assert reset during BUSY_I -> m_req=0 same cycle, no i_valid/i_err; after release pending d_req granted normally.
